// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_store_unit : RV32I memory-stage LSU with valid/ready data port.      |
// | Optional RESP timeout when LSU_TIMEOUT_EN is defined.                     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        write_enable,
  output logic [4:0]  rd,
  output logic [31:0] dmem_out,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  req_rd_q, req_rd_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] dmem_q, dmem_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic        wb_valid_q, wb_valid_d;
  logic        write_enable_q, write_enable_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        aligned, funct3_ok, access_ok;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

`ifdef LSU_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_comb begin
    aligned = 1'b0;
    case (req_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    funct3_ok = req_we ? (req_funct3 < 3'd3)
                       : !(req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
    access_ok = aligned && funct3_ok;
  end

  // Lane extraction uses the captured address, not the live request
  always_comb begin
    load_byte = 8'h00;
    case (addr_q[1:0])
      2'b00: load_byte = mem_rdata[7:0];
      2'b01: load_byte = mem_rdata[15:8];
      2'b10: load_byte = mem_rdata[23:16];
      2'b11: load_byte = mem_rdata[31:24];
      default: load_byte = 8'h00;
    endcase
    load_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'h000000, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'h0000, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    mem_wstrb = 4'b0000;
    case (funct3_q[1:0])
      2'b00:   mem_wdata = {4{wdata_q[7:0]}};
      2'b01:   mem_wdata = {2{wdata_q[15:0]}};
      default: mem_wdata = wdata_q;
    endcase
    if (we_q) begin
      case (funct3_q[1:0])
        2'b00:   mem_wstrb = 4'b0001 << addr_q[1:0];
        2'b01:   mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        default: mem_wstrb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    req_rd_d       = req_rd_q;
    rd_d           = rd_q;
    dmem_d         = dmem_q;
    fault_addr_d   = fault_addr_q;
    wb_valid_d     = 1'b0;
    write_enable_d = 1'b0;
    misalign_d     = 1'b0;
    bus_err_d      = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d          = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          req_rd_d = req_rd;
          if (access_ok) begin
            state_d = REQ;
          end else begin
            misalign_d   = 1'b1;
            fault_addr_d = req_addr;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          if (we_q) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            rd_d       = req_rd_q;
          end else begin
            state_d = RESP;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = 16'd0;
`endif
          end
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          state_d        = IDLE;
          dmem_d         = load_data;
          wb_valid_d     = 1'b1;
          write_enable_d = 1'b1;
          rd_d           = req_rd_q;
        end
`ifdef LSU_TIMEOUT_EN
        // Fires in the cycle the count would reach TIMEOUT
        else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d      = IDLE;
          bus_err_d    = 1'b1;
          wb_valid_d   = 1'b1;
          fault_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      we_q           <= 1'b0;
      funct3_q       <= 3'b000;
      addr_q         <= 32'h0;
      wdata_q        <= 32'h0;
      req_rd_q       <= 5'd0;
      rd_q           <= 5'd0;
      dmem_q         <= 32'h0;
      fault_addr_q   <= 32'h0;
      wb_valid_q     <= 1'b0;
      write_enable_q <= 1'b0;
      misalign_q     <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      funct3_q       <= funct3_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      req_rd_q       <= req_rd_d;
      rd_q           <= rd_d;
      dmem_q         <= dmem_d;
      fault_addr_q   <= fault_addr_d;
      wb_valid_q     <= wb_valid_d;
      write_enable_q <= write_enable_d;
      misalign_q     <= misalign_d;
      bus_err_q      <= bus_err_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign req_ready    = (state_q == IDLE);
  assign stall        = (state_q != IDLE);
  assign mem_valid    = (state_q == REQ);
  assign mem_we       = we_q;
  assign mem_addr     = {addr_q[31:2], 2'b00};
  assign wb_valid     = wb_valid_q;
  assign write_enable = write_enable_q;
  assign rd           = rd_q;
  assign dmem_out     = dmem_q;
  assign misalign     = misalign_q;
  assign bus_err      = bus_err_q;
  assign fault_addr   = fault_addr_q;

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit of the RISC-V pipeline, directly upstream of the register file's write-back path. It accepts one load or store per transaction from the MEM stage and drives a valid/ready data-memory port with word-aligned address, replicated store data and byte strobes. For loads it lane-extracts and sign/zero-extends the returned word into `dmem_out`, the value selected by WBSel=0 at write-back. It stalls the pipeline while a transaction is outstanding and flags misaligned or illegal accesses.

## Interface
- `TIMEOUT`, default 255: cycles to wait for `mem_rvalid` before aborting; legal range 1..65535; only used with `LSU_TIMEOUT_EN`.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_valid` in 1: MEM stage presents a load/store.
- `req_ready` out 1: request accepted this cycle; equals (state==IDLE).
- `req_we` in 1: 1=store, 0=load.
- `req_funct3` in 3: RV32I load/store funct3.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data (rs2).
- `req_rd` in 5: load destination register.
- `stall` out 1: high while state!=IDLE.
- `mem_valid` out 1: memory request valid.
- `mem_ready` in 1: memory accepts the request.
- `mem_we` out 1: memory write.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: replicated store data.
- `mem_wstrb` out 4: byte strobes; 0 for loads.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `wb_valid` out 1: one-cycle completion pulse.
- `write_enable` out 1: qualifies `wb_valid` for the register-file write; 1 only for a completed load.
- `rd` out 5: captured `req_rd`.
- `dmem_out` out 32: aligned, extended load result.
- `misalign` out 1: one-cycle exception pulse.
- `bus_err` out 1: one-cycle timeout pulse.
- `fault_addr` out 32: address of the last faulting request.

## Operation
- States: IDLE, REQ, RESP.
- IDLE, `req_valid`=1:
  - Capture `we`, `funct3`, `addr`, `wdata` and `rd`.
  - Legal access: go to REQ.
  - Misaligned or illegal access: stay in IDLE; next cycle `misalign`=1 and `fault_addr`=addr; no memory access and no `wb_valid`.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
- Illegal funct3: loads 011/110/111; stores ≥011.
- REQ:
  - `mem_valid`=1. Address, data, strobes and `we` are held stable until `mem_ready`.
  - On `mem_ready`, a store completes: go to IDLE, `wb_valid`=1 and `write_enable`=0 next cycle.
  - On `mem_ready`, a load goes to RESP.
- RESP:
  - On `mem_rvalid`, register the extracted result into `dmem_out`, pulse `wb_valid`=1 and `write_enable`=1, go to IDLE.
  - `mem_rvalid` in IDLE or REQ is ignored.
- Store encoding:
  - SB: wdata={4{b}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wstrb=4'b1111.
- Load extraction: select byte lane addr[1:0] or halfword lane addr[1].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- `dmem_out` and `rd` hold their values until the next completion.

## Timing
- Reset values: state=IDLE. `mem_valid`, `mem_we`, `mem_wstrb`, `wb_valid`, `write_enable`, `misalign`, `bus_err` and `stall` are 0. `mem_addr`, `mem_wdata`, `dmem_out`, `rd` and `fault_addr` are 0. `req_ready`=1.
- Reset in any state aborts the transaction immediately, with no `wb_valid`, and drops `mem_valid` the next cycle.
- Load, zero wait states: accept at N, `mem_valid` at N+1, `mem_ready` at N+1, `mem_rvalid` at N+2, `wb_valid` at N+3.
- Store, zero wait states: `wb_valid` at N+2.
- Back-to-back: a new request is accepted in the cycle `wb_valid` is high, because the state is IDLE.
- `stall` is combinational from the state: high from N+1 until the cycle before `wb_valid`.
- `mem_valid` never drops before `mem_ready`.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entering RESP and increments each RESP cycle without `mem_rvalid`.
  - When the count reaches TIMEOUT: go to IDLE, pulse `bus_err`=1 and `wb_valid`=1 with `write_enable`=0, and set `fault_addr`=addr.
  - `mem_rvalid` arriving in the same cycle as the TIMEOUT count wins over the timeout.
- `LSU_TIMEOUT_EN` undefined: no counter; RESP waits indefinitely; `bus_err` is tied to 0.

## Test plan
- LB addr=0x1003, rdata=0x80FF_0011 → `mem_addr`=0x1000, `dmem_out`=0xFFFF_FF80, `write_enable`=1, `wb_valid` 3 cycles after acceptance. LBU on the same access → 0x0000_0080.
- SH addr=0x2002, wdata=0x1234_ABCD, `mem_ready` held low 2 cycles → `mem_wdata`=0xABCD_ABCD and `wstrb`=1100 held stable; `wb_valid`=1 with `write_enable`=0.
- LW addr=0x3001 → `misalign` pulse, `fault_addr`=0x3001, `mem_valid` never asserted, `stall` stays 0.
- With `LSU_TIMEOUT_EN`, TIMEOUT=4, LW with no `mem_rvalid` → `bus_err` and `wb_valid` pulse 4 cycles after entering RESP, `write_enable`=0. Without the macro, the unit is still stalled after 100 cycles.
- `rst_n`=0 while in RESP → next cycle IDLE with all outputs at reset values; a late `mem_rvalid` produces no `wb_valid`.
- SW to 0x10 then LW from 0x10, back-to-back → second request accepted in the first `wb_valid` cycle; the load returns the stored word.
